// File: rtl/gpio_input_conditioner_pkg.sv
// Shared constants and types for the GPIO input conditioner: board defaults,
// the per-bit edge event record and the debounce counter width helper.
package gpio_input_conditioner_pkg;

   localparam int MPRJ_IO_PADS        = 38;
   localparam int GPIO_COND_WIDTH     = MPRJ_IO_PADS - 2;
   localparam int DEBOUNCE_1MS_48MHZ  = 48000;
   localparam int SYNC_STAGES_DEFAULT = 2;

   typedef struct packed {
      logic rise;
      logic fall;
   } edge_evt_t;

   // Counter must hold DEBOUNCE_CYCLES-1 with headroom for the +1 compare range.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/gpio_input_conditioner_if.sv
// Pad-side and emulator-side signal bundle of the GPIO input conditioner.
interface gpio_input_conditioner_if
   import gpio_input_conditioner_pkg::*;
#(
   parameter int WIDTH = GPIO_COND_WIDTH
);

   logic [WIDTH-1:0] pad_i;
   logic [WIDTH-1:0] bypass_i;
   logic [WIDTH-1:0] io_in_o;
   logic [WIDTH-1:0] rise_o;
   logic [WIDTH-1:0] fall_o;
   logic             changed_o;

   modport slave (
      input  pad_i, bypass_i,
      output io_in_o, rise_o, fall_o, changed_o
   );

   modport master (
      output pad_i, bypass_i,
      input  io_in_o, rise_o, fall_o, changed_o
   );

endinterface

// File: rtl/gpio_input_conditioner_debounce_bit.sv
// One conditioned input: synchroniser chain, debounce counter, stable level
// and one-cycle rise/fall events.
module gpio_debounce_bit
   import gpio_input_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_48MHZ,
   parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
   input  logic      i_clk,
   input  logic      i_rst,
   input  logic      i_pad,
   input  logic      i_bypass,
   output logic      o_stable,
   output edge_evt_t o_evt
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_stable;
   logic [CNT_W-1:0]       r_cnt;
   edge_evt_t              r_evt;

   logic w_sync;
   logic w_mismatch;
   logic w_accept;

   assign w_sync     = r_sync[SYNC_STAGES-1];
   assign w_mismatch = w_sync ^ r_stable;
   // Reaching CNT_LAST on a mismatch edge is the DEBOUNCE_CYCLES-th disagreeing sample.
   assign w_accept   = w_mismatch & (i_bypass | (r_cnt == CNT_LAST));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync   <= '0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
         r_evt    <= '0;
      end else begin
         r_sync     <= {r_sync[SYNC_STAGES-2:0], i_pad};
         r_evt.rise <= w_accept & w_sync;
         r_evt.fall <= w_accept & ~w_sync;
         if (!w_mismatch || w_accept) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_accept) begin
            r_stable <= w_sync;
         end
      end
   end

   assign o_stable = r_stable;
   assign o_evt    = r_evt;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Conditions WIDTH asynchronous pad inputs into debounced levels plus edge
// events, and flags any event one cycle later on changed_o.
module gpio_input_conditioner
   import gpio_input_conditioner_pkg::*;
#(
   parameter int WIDTH           = GPIO_COND_WIDTH,
   parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_48MHZ
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   gpio_input_conditioner_if.slave  bus
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

   logic [WIDTH-1:0] w_stable;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic             r_changed;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      edge_evt_t w_evt;

      gpio_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_bit (
         .i_clk    (wb_clk_i),
         .i_rst    (wb_rst_i),
         .i_pad    (bus.pad_i[g]),
         .i_bypass (bus.bypass_i[g]),
         .o_stable (w_stable[g]),
         .o_evt    (w_evt)
      );

      assign w_rise[g] = w_evt.rise;
      assign w_fall[g] = w_evt.fall;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_changed <= 1'b0;
      end else begin
         r_changed <= |(w_rise | w_fall);
      end
   end

   assign bus.io_in_o   = w_stable;
   assign bus.rise_o    = w_rise;
   assign bus.fall_o    = w_fall;
   assign bus.changed_o = r_changed;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Scoreboard bench: a driver pushes the modelled outcome of every clock edge,
// a monitor pops and compares it against the DUT shortly after that edge.
module tb_gpio_input_conditioner;
   import gpio_input_conditioner_pkg::*;

   localparam int W    = 4;
   localparam int SYNC = 2;
   localparam int DEB  = 4;

   typedef struct {
      logic [W-1:0] io;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic         chg;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gpio_input_conditioner_if #(.WIDTH(W)) bus ();

   gpio_input_conditioner #(
      .WIDTH           (W),
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus)
   );

   exp_t         exp_q[$];
   logic [W-1:0] hist[$];
   logic [W-1:0] m_io, m_rise, m_fall;
   logic         m_chg;
   int           checks = 0;
   int           passes = 0;
   logic [W-1:0] cur_pad = '0;
   logic [W-1:0] cur_byp = '0;

   initial begin
      bus.pad_i    = '0;
      bus.bypass_i = '0;
   end

   // Level the debounce stage sees at post-reset edge e: the pad sampled SYNC edges earlier.
   function automatic logic seen(input int e, input int b);
      int idx;
      idx = e - 1 - SYNC;
      if (idx < 0) return 1'b0;
      return hist[idx][b];
   endfunction

   // A level is accepted once the last `win` seen samples all disagree with it.
   task automatic model_edge(input logic r, input logic [W-1:0] pad, input logic [W-1:0] byp);
      int e, win;
      logic flip;
      if (r) begin
         hist.delete();
         m_io = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
      end else begin
         m_chg = |(m_rise | m_fall);
         hist.push_back(pad);
         e = hist.size();
         for (int b = 0; b < W; b++) begin
            win  = byp[b] ? 1 : DEB;
            flip = 1'b1;
            for (int k = 0; k < win; k++)
               if (seen(e - k, b) == m_io[b]) flip = 1'b0;
            m_rise[b] = flip & ~m_io[b];
            m_fall[b] = flip & m_io[b];
            if (flip) m_io[b] = ~m_io[b];
         end
      end
      exp_q.push_back('{io: m_io, rise: m_rise, fall: m_fall, chg: m_chg});
   endtask

   task automatic step(input logic r, input logic [W-1:0] pad, input logic [W-1:0] byp);
      @(negedge clk);
      rst          = r;
      bus.pad_i    = pad;
      bus.bypass_i = byp;
      model_edge(r, pad, byp);
   endtask

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("io_in_o",   bus.io_in_o, e.io);
            chk("rise_o",    bus.rise_o,  e.rise);
            chk("fall_o",    bus.fall_o,  e.fall);
            chk("changed_o", {{(W-1){1'b0}}, bus.changed_o}, {{(W-1){1'b0}}, e.chg});
            chk("rise_and_fall", bus.rise_o & bus.fall_o, '0);
         end
      end
   end

   initial begin : driver
      logic [3:0] bounce [9];
      bounce = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

      // Reset with all pads high, then release and hold.
      repeat (2) step(1'b1, 4'hF, 4'h0);
      repeat (10) step(1'b0, 4'hF, 4'h0);

      // Short glitch on bit 0 must be rejected.
      repeat (2) step(1'b1, 4'h0, 4'h0);
      repeat (3) step(1'b0, 4'h0, 4'h0);
      repeat (3) step(1'b0, 4'h1, 4'h0);
      repeat (10) step(1'b0, 4'h0, 4'h0);

      // Bouncing bit 1 settles high.
      for (int i = 0; i < 9; i++) step(1'b0, {2'b00, bounce[i][0], 1'b0}, 4'h0);
      repeat (10) step(1'b0, 4'h2, 4'h0);

      // Bypassed bit 2 toggling every 5 cycles.
      cur_pad = 4'h2;
      for (int t = 0; t < 6; t++) begin
         cur_pad[2] = ~cur_pad[2];
         repeat (5) step(1'b0, cur_pad, 4'h4);
      end

      // Simultaneous rises on bits 3 and 1.
      repeat (2) step(1'b1, 4'h0, 4'h0);
      repeat (3) step(1'b0, 4'h0, 4'h0);
      repeat (10) step(1'b0, 4'hA, 4'h0);

      // Reset mid-count on bit 0, pad stays high.
      repeat (2) step(1'b1, 4'h0, 4'h0);
      repeat (4) step(1'b0, 4'h1, 4'h0);
      step(1'b1, 4'h1, 4'h0);
      repeat (10) step(1'b0, 4'h1, 4'h0);

      // Randomised traffic: short and long pulses, occasional bypass flips and resets.
      cur_pad = 4'h1;
      cur_byp = '0;
      for (int c = 0; c < 2000; c++) begin
         for (int b = 0; b < W; b++) begin
            if ($urandom_range(0, 5) == 0)  cur_pad[b] = ~cur_pad[b];
            if ($urandom_range(0, 63) == 0) cur_byp[b] = ~cur_byp[b];
         end
         step(($urandom_range(0, 199) == 0), cur_pad, cur_byp);
      end

      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", W'(exp_q.size()), '0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
- Sits between the FPGA pad tristate buffers and the emulator's io_in bus, on the wb_clk_i domain.
- Conditions every asynchronous GPIO/button input in three steps:
  - multi-flop synchroniser;
  - per-bit debounce counter, which a per-bit bypass can skip for fast serial pins;
  - one-cycle rise/fall event flags.
- Outputs are glitch-free, registered levels for the emulator, plus edge events that downstream logic (e.g. an LED stretcher or IRQ source) can consume.

Parameters:
- WIDTH, 36, number of conditioned inputs (`MPRJ_IO_PADS` − 2 reserved).
- SYNC_STAGES, 2, synchroniser depth; legal ≥ 2.
- DEBOUNCE_CYCLES, 48000, consecutive stable cycles required before a level is accepted (1 ms at 48 MHz); legal ≥ 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden).

Ports:
- wb_clk_i  input  1  system clock (48 MHz on board).
- wb_rst_i  input  1  synchronous, active-high reset.
- pad_i  input  WIDTH  raw asynchronous pad levels from the tristate buffers.
- bypass_i  input  WIDTH  per bit: 1 = skip debounce (synchroniser only). Quasi-static.
- io_in_o  output  WIDTH  conditioned levels to the emulator io_in.
- rise_o  output  WIDTH  one-cycle pulse when io_in_o[i] goes 0→1.
- fall_o  output  WIDTH  one-cycle pulse when io_in_o[i] goes 1→0.
- changed_o  output  1  one-cycle pulse, registered OR of rise_o|fall_o for the same cycle.

Behaviour:
- Reset (wb_rst_i=1 at an edge) clears the following to 0:
  - all synchroniser flops, stable registers and counters;
  - io_in_o, rise_o, fall_o and changed_o.
- No edge events are generated by reset itself.
- Synchroniser: a SYNC_STAGES-deep shift per bit. sync[i] reflects pad_i[i] after SYNC_STAGES edges. No logic is placed between the flops.
- Debounce state per bit: stable[i] drives io_in_o[i]; cnt[i] is CNT_W bits.
- Debounce update, per bit, per edge (not in reset):
  - If sync==stable: cnt ← 0.
  - Else, if bypass_i[i]=1 or cnt==DEBOUNCE_CYCLES−1:
    - stable ← sync and cnt ← 0;
    - rise_o[i] ← sync and fall_o[i] ← ~sync at this same edge.
  - Else: cnt ← cnt+1.
- rise_o/fall_o are 0 on every edge where stable does not change. They are never both 1 for the same bit.
- Latency: if pad_i is held, io_in_o changes exactly SYNC_STAGES + DEBOUNCE_CYCLES edges after the first edge that samples the new level.
  - With bypass, the latency is SYNC_STAGES + 1.
  - DEBOUNCE_CYCLES=1 gives the same latency as bypass.
- Glitch rejection: any mismatch run shorter than DEBOUNCE_CYCLES edges clears cnt and leaves io_in_o, rise_o and fall_o unchanged.
- Bouncing input: each return to the stable level restarts the count from 0. There is no accumulation across bounces.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES−1. No wrap-around is possible.
- bypass_i rising while cnt>0: on the next mismatch edge, stable takes sync immediately and cnt clears.
- bypass_i falling: a new count starts from the current cnt, which is 0 because bypass clears it.
- Reset asserted mid-count: the count is discarded and all outputs are 0 at the following edge.
  - After reset release, a pad held at 1 produces io_in_o=1 and a rise_o pulse after the normal latency.
- changed_o is registered one edge after the rise/fall pulses. It is 0 during reset and on the first edge after reset.
- Bits are fully independent. Simultaneous events on multiple bits each produce their own pulses in the same cycle.

Decomposition:
- Shared header gpio_cond_defs.vh contains:
  - `GPIO_COND_WIDTH (`MPRJ_IO_PADS−2);
  - `DEBOUNCE_1MS_48MHZ (48000);
  - `SYNC_STAGES_DEFAULT (2).
- Sub-module gpio_debounce_bit holds the synchroniser chain, counter, stable register and rise/fall generation for one bit. The top instantiates WIDTH copies via generate and adds the changed_o reduction register.

Test Plan (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless noted):
- Reset with pad_i=4'hF, then release, hold 8 edges → io_in_o=0 until post-release edge 6, then 4'hF; rise_o=4'hF for exactly one cycle at edge 6; changed_o=1 at edge 7.
- pad_i[0] pulses 1 for 3 cycles then 0, bypass=0 → io_in_o[0] stays 0; rise_o/fall_o stay 0 throughout.
- pad_i[1] bounces 1,0,1,1,0,1,1,1,1 then holds 1 → exactly one rise_o[1] pulse, 6 edges after the final 0→1 sample; no fall_o[1].
- bypass_i[2]=1, pad_i[2] toggles each 5 cycles → io_in_o[2] follows with 3-edge latency; alternating rise_o/fall_o pulses, one per toggle.
- Simultaneous: pad_i[3:0] 0→4'b1010 with bypass=0 → rise_o=4'b1010 in a single cycle; changed_o single pulse the next cycle.
- Assert wb_rst_i for 1 cycle when cnt[0]=2 mid-transition → io_in_o=0 next edge; if the pad stays 1, rise_o[0] fires 6 edges after release.
